// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix multiplier processing elements.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE
  } pe_state_t;

  // Result width that cannot overflow: k products of two full-scale negatives.
  function automatic int pe_acc_w(input int data_w, input int k);
    return 2 * data_w + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Signed multiply-accumulate slice: acc clears on clr, else adds a*b when en.
module pe_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/matrix_pe.sv
// Processing element: latches a row/column pair, forms their dot product one
// MAC per cycle, then pushes the result into the result FIFO.
module matrix_pe
  import matrix_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int K      = 2,
  parameter int ACC_W  = pe_acc_w(DATA_W, K)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_PE,
  input  logic [K*DATA_W-1:0]   row_vec,
  input  logic [K*DATA_W-1:0]   col_vec,
  input  logic                  fifo_full,
  output logic                  PE_ready,
  output logic                  fifo_push,
  output logic [ACC_W-1:0]      fifo_data,
  output logic                  protocol_err
);

  localparam int            KW     = (K > 1) ? $clog2(K) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  pe_state_t                state;
  logic [KW-1:0]            k;
  logic signed [DATA_W-1:0] row_q [K];
  logic signed [DATA_W-1:0] col_q [K];
  logic signed [ACC_W-1:0]  acc;
  logic                     accept;

  assign accept = (state == IDLE) && start_PE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (start_PE && (state != IDLE)) begin
        protocol_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_PE) begin
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          k <= k + KW'(1);
          if (k == K_LAST) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (!fifo_full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: operand latches carry no reset; they are always loaded on accept before MAC reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K; i++) begin
        row_q[i] <= row_vec[i*DATA_W +: DATA_W];
        col_q[i] <= col_vec[i*DATA_W +: DATA_W];
      end
    end
  end

  pe_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == MAC),
    .a     (row_q[k]),
    .b     (col_q[k]),
    .acc   (acc)
  );

  // PE_ready decodes only the state register, so the control unit may gate start_PE on it.
  assign PE_ready  = (state == IDLE);
  assign fifo_push = (state == WRITE) && !fifo_full;
  assign fifo_data = acc;

endmodule

// File: tb/tb_matrix_pe.sv
// Randomized self-checking bench for matrix_pe against a plain-arithmetic dot-product model.
module tb_matrix_pe;

  localparam int DATA_W = 8;
  localparam int K      = 2;
  localparam int ACC_W  = 18;
  localparam int VW     = K * DATA_W;

  logic             clk;
  logic             rst_n;
  logic             start_PE;
  logic [VW-1:0]    row_vec;
  logic [VW-1:0]    col_vec;
  logic             fifo_full;
  logic             PE_ready;
  logic             fifo_push;
  logic [ACC_W-1:0] fifo_data;
  logic             protocol_err;

  matrix_pe #(
    .DATA_W (DATA_W),
    .K      (K),
    .ACC_W  (ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_PE     (start_PE),
    .row_vec      (row_vec),
    .col_vec      (col_vec),
    .fifo_full    (fifo_full),
    .PE_ready     (PE_ready),
    .fifo_push    (fifo_push),
    .fifo_data    (fifo_data),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Push monitor: counts every push and remembers when the last two happened.
  int push_cnt  = 0;
  int last_push = -1;
  int prev_push = -1;
  always @(negedge clk) begin
    #2;
    if (fifo_push === 1'b1) begin
      push_cnt++;
      prev_push = last_push;
      last_push = cyc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int e0, input int e1);
    return {DATA_W'(e1), DATA_W'(e0)};
  endfunction

  function automatic logic [ACC_W-1:0] ref_dot(input logic [VW-1:0] r, input logic [VW-1:0] c);
    longint sum = 0;
    for (int i = 0; i < K; i++) begin
      sum += longint'($signed(r[i*DATA_W +: DATA_W])) * longint'($signed(c[i*DATA_W +: DATA_W]));
    end
    return ACC_W'(sum);
  endfunction

  // Called at a negedge with PE_ready expected high. Holds fifo_full for `stall`
  // cycles once WRITE is reached; `glitch` (offset from the first MAC cycle, -1 for
  // none) pulses start_PE with fresh operands while the PE is busy.
  task automatic run_dot(input logic [VW-1:0] row, input logic [VW-1:0] col,
                         input logic [ACC_W-1:0] exp, input int stall,
                         input int glitch, input string tag);
    int e0;
    row_vec   = row;
    col_vec   = col;
    start_PE  = 1'b1;
    fifo_full = 1'b0;
    #1;
    check({tag, "/ready_pre"}, PE_ready, 1);
    @(negedge clk);
    e0 = cyc;
    for (int c = e0; c <= e0 + K + stall; c++) begin
      if (c != e0) @(negedge clk);
      start_PE = (c == e0 + glitch);
      if (start_PE || c == e0) begin
        row_vec = VW'($urandom);
        col_vec = VW'($urandom);
      end
      fifo_full = (c < e0 + K) ? 1'($urandom) : (c < e0 + K + stall);
      #1;
      check({tag, "/push"}, fifo_push, (c == e0 + K + stall));
      check({tag, "/ready_busy"}, PE_ready, 0);
      if (c >= e0 + K) check({tag, "/data"}, fifo_data, exp);
    end
    @(negedge clk);
    start_PE  = 1'b0;
    fifo_full = 1'b0;
    #1;
    check({tag, "/ready_post"}, PE_ready, 1);
    check({tag, "/push_post"}, fifo_push, 0);
  endtask

  initial begin
    int n0;
    logic [VW-1:0] r, c;
    rst_n     = 1'b0;
    start_PE  = 1'b0;
    fifo_full = 1'b0;
    row_vec   = '0;
    col_vec   = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst/ready", PE_ready, 1);
    check("rst/push", fifo_push, 0);
    check("rst/data", fifo_data, 0);
    check("rst/perr", protocol_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_dot(pack(3, 4), pack(5, 6), 18'd39, 0, -1, "basic");
    run_dot(pack(-2, 7), pack(3, -1), 18'h3FFF3, 0, -1, "signed");
    run_dot(pack(-128, -128), pack(-128, -128), 18'd32768, 0, -1, "extreme");

    n0 = push_cnt;
    run_dot(pack(1, 2), pack(3, 4), 18'd11, 0, -1, "b2b_a");
    run_dot(pack(-5, 9), pack(6, 2), 18'h3FFF4, 0, -1, "b2b_b");
    check("b2b/pushes", push_cnt - n0, 2);
    check("b2b/spacing", last_push - prev_push, K + 2);
    check("b2b/perr", protocol_err, 0);

    run_dot(pack(10, -20), pack(7, 3), 18'd10, 6, -1, "bp");

    for (int i = 0; i < 8; i++) begin
      r = VW'($urandom);
      c = VW'($urandom);
      run_dot(r, c, ref_dot(r, c), int'($urandom_range(0, 3)), -1, "rand");
    end
    check("rand/perr", protocol_err, 0);

    n0 = push_cnt;
    run_dot(pack(2, 3), pack(4, 5), 18'd23, 0, 0, "perr_mac");
    check("perr_mac/pushes", push_cnt - n0, 1);
    check("perr_mac/perr", protocol_err, 1);
    run_dot(pack(1, 1), pack(1, 1), 18'd2, 1, K + 1, "perr_wr");
    check("perr_wr/perr", protocol_err, 1);

    row_vec  = pack(9, 9);
    col_vec  = pack(9, 9);
    start_PE = 1'b1;
    @(negedge clk);
    start_PE = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst/ready", PE_ready, 1);
    check("midrst/push", fifo_push, 0);
    check("midrst/data", fifo_data, 0);
    check("midrst/perr", protocol_err, 0);
    n0 = push_cnt;
    repeat (4) @(negedge clk);
    check("midrst/nopush", push_cnt - n0, 0);
    rst_n = 1'b1;
    run_dot(pack(1, 1), pack(2, 2), 18'd4, 0, -1, "post_rst");
    check("post_rst/perr", protocol_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
